ddr_capture_client: RTL and testbench
=====================================

Name: ddr_capture_client

Overview:
- Requester-side client of the DDR memory interface command/return handshake.
- Capture phase: packs a stream of 16-bit logic-analyzer samples into 128-bit words and issues them as sequential write requests.
- Readback phase: issues sequential read requests, consumes the returned data, and unpacks it into a 16-bit sample stream with a valid/ready handshake.
- Sits between the sampler/trigger logic and the memory interface, in the soc clock domain.

Parameters:
- BASE_ADX, 27'd0: first DDR address of the capture region.
- DEPTH_WORDS, 1024: number of 128-bit words per capture. Legal range is 1 to 2^20.
- ADX_STEP, 8: address increment per 128-bit word, in 16-bit DDR column units.

Ports:
- clk  in  1  soc clock.
- reset  in  1  asynchronous, active-high reset.
- start_capture  in  1  single-cycle pulse; honoured only in IDLE.
- start_readback  in  1  single-cycle pulse; honoured only in IDLE.
- sample_in  in  16  sample data.
- sample_valid  in  1  sample_in is valid this cycle.
- busy  out  1  high in any state other than IDLE.
- capture_done  out  1  sticky; set when a capture fully drains; cleared by start_capture.
- overflow  out  1  sticky; a completed word was dropped; cleared by start_capture.
- adx_error  out  1  sticky; a return address mismatched; cleared by start_readback.
- wr_adx_out  out  27  write address.
- wr_data_out  out  128  write data.
- write_req  out  1  write request.
- write_allowed  in  1  memory interface accepts a write this cycle.
- writes_pending  in  1  writes still queued toward the controller.
- rd_adx_out  out  27  read address.
- read_req  out  1  read request.
- read_allowed  in  1  memory interface accepts a read this cycle.
- reads_pending  in  1  reads still outstanding.
- rd_data_return  in  128  returned read data.
- rd_adx_return  in  27  address of the returned data.
- has_return_data  in  1  return data is available.
- get_return_data  out  1  pops one return entry.
- out_sample  out  16  unpacked sample.
- out_valid  out  1  out_sample is valid.
- out_ready  in  1  downstream accepts out_sample.

Behaviour:

Reset:
- Every output is 0.
- State is IDLE; all counters and holding registers are cleared.
- Reset mid-operation aborts immediately. Requests already issued are not recalled.

State machine: IDLE, CAPTURE, DRAIN, RD_ISSUE, DONE.
- IDLE → CAPTURE on start_capture. On entry: pack index = 0, word count = 0, write address = BASE_ADX.
- IDLE → RD_ISSUE on start_readback. On entry: read issue count = 0, return count = 0, expected return address = BASE_ADX.
- If start_capture and start_readback arrive in the same cycle, capture wins.

Capture packing:
- Each cycle with sample_valid in CAPTURE, sample k (k = 0..7) is stored at bits [16k+15:16k].
- On the 8th sample, the packed word moves to a one-entry hold register (hold_valid = 1) in the same cycle.
- If hold_valid is still 1 when a new word completes, the new word is discarded, overflow is set, and the word count still advances.
- Samples arriving outside CAPTURE are ignored.

Write issue:
- write_req = hold_valid & write_allowed, combinational on registered state.
- wr_adx_out / wr_data_out come from the hold register.
- On write_req: hold_valid clears, the write address advances by ADX_STEP (wrapping modulo 2^27), and the words-written count increments.
- Latency from 8th sample to write_req is 1 cycle when write_allowed is high.

Capture end:
- Once DEPTH_WORDS words have been completed (written or dropped) and hold_valid = 0: CAPTURE → DRAIN.
- Samples after the final word are ignored.
- DRAIN → DONE when writes_pending = 0. DONE sets capture_done and returns to IDLE on the next cycle.

Read issue (RD_ISSUE):
- read_req = read_allowed & (issued < DEPTH_WORDS).
- rd_adx_out = BASE_ADX + issued × ADX_STEP.

Return path (active in RD_ISSUE):
- get_return_data pulses for one cycle when has_return_data = 1 and the unpack register is empty.
- In that same cycle rd_data_return is loaded into the unpack register, and the next cycle presents sample 0.
- Each out_valid & out_ready handshake advances the sample index. After sample 7 is accepted, the register is empty.
- out_sample is held stable while out_valid & ~out_ready.
- Issue and consume proceed concurrently.
- RD_ISSUE → DONE when returned == DEPTH_WORDS, the unpack register is empty, and reads_pending = 0. Then → IDLE.

Counters:
- Word counters are 21 bits wide.
- Address arithmetic is 27 bits wide and wraps.

Optional Feature:
- RD_ADX_CHECK_EN defined:
  - On each get_return_data, rd_adx_return is compared with the expected return address, which advances by ADX_STEP per return.
  - A mismatch sets adx_error; the data is still unpacked.
- RD_ADX_CHECK_EN undefined:
  - rd_adx_return is ignored.
  - adx_error is tied to 0.

Test Plan:
1. DEPTH_WORDS=2, write_allowed=1, samples 16'h0000..16'h000F → two write_req pulses:
   - adx 0: data 128'h0007_0006_0005_0004_0003_0002_0001_0000
   - adx 8: next word
   - then capture_done=1 after writes_pending drops.
2. write_allowed=0 while 16 samples stream continuously → first word held; second word dropped with overflow=1; on write_allowed=1 exactly one write at adx 0.
3. DEPTH_WORDS=3, read_allowed toggling, memory model returning 128'h...0001_0000 style words → reads at adx 0, 8, 16; 24 out_samples in order; out_ready stalls keep out_sample stable.
4. RD_ADX_CHECK_EN with return adx 16 where 8 is expected → adx_error=1; samples still delivered.
5. Reset asserted mid-readback after 1 of 3 returns → all outputs 0 in the same cycle; IDLE; a subsequent start_capture works normally.
6. BASE_ADX=27'h7FFFFF8, DEPTH_WORDS=2 → writes at 27'h7FFFFF8, then 27'h0000000 (wrap).

Source files
------------

// File: rtl/ddr_capture_client.sv
// ddr_capture_client
//   Requester-side client of the DDR command/return handshake (soc clock domain).
//   Capture: packs 16-bit samples into 128-bit words and writes them sequentially
//   from BASE_ADX. Readback: reads the same region back and unpacks it into a
//   16-bit valid/ready sample stream.
//
//   Optional feature macro: RD_ADX_CHECK_EN -- compare each returned address with
//   the expected sequence and flag mismatches on adx_error (tied 0 otherwise).
//
// Ports
//   clk, reset                      soc clock, async active-high reset
//   start_capture, start_readback   single-cycle starts, honoured in IDLE only
//   sample_in, sample_valid         capture sample stream
//   busy                            not in IDLE
//   capture_done, overflow          sticky capture status (cleared by start_capture)
//   adx_error                       sticky return-address mismatch (cleared by start_readback)
//   wr_adx_out, wr_data_out,
//   write_req, write_allowed,
//   writes_pending                  write command channel
//   rd_adx_out, read_req,
//   read_allowed, reads_pending     read command channel
//   rd_data_return, rd_adx_return,
//   has_return_data, get_return_data  read return channel
//   out_sample, out_valid, out_ready  unpacked readback stream
module ddr_capture_client #(
    parameter logic [26:0] BASE_ADX    = 27'd0,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADX_STEP    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_capture,
    input  logic         start_readback,
    input  logic [15:0]  sample_in,
    input  logic         sample_valid,
    output logic         busy,
    output logic         capture_done,
    output logic         overflow,
    output logic         adx_error,
    output logic [26:0]  wr_adx_out,
    output logic [127:0] wr_data_out,
    output logic         write_req,
    input  logic         write_allowed,
    input  logic         writes_pending,
    output logic [26:0]  rd_adx_out,
    output logic         read_req,
    input  logic         read_allowed,
    input  logic         reads_pending,
    input  logic [127:0] rd_data_return,
    input  logic [26:0]  rd_adx_return,
    input  logic         has_return_data,
    output logic         get_return_data,
    output logic [15:0]  out_sample,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned CNT_W = 21;
    localparam int unsigned ADX_W = 27;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);
    localparam logic [ADX_W-1:0] STEP      = ADX_W'(ADX_STEP);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CAPTURE  = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       state, state_nxt;

    logic [111:0]     pack_data;
    logic [2:0]       pack_idx;
    logic [CNT_W-1:0] word_cnt;
    logic             hold_valid;
    logic [127:0]     hold_data;
    logic [ADX_W-1:0] wr_adx;

    logic [CNT_W-1:0] issue_cnt;
    logic [ADX_W-1:0] rd_adx;
    logic [CNT_W-1:0] ret_cnt;
    logic             unpack_valid;
    logic [127:0]     unpack_data;
    logic [2:0]       unpack_idx;

    logic start_cap_c;
    logic start_rd_c;
    logic sample_take_c;
    logic word_complete_c;
    logic out_accept_c;

    // Capture wins when both starts arrive together.
    assign start_cap_c     = (state == S_IDLE) && start_capture;
    assign start_rd_c      = (state == S_IDLE) && start_readback && !start_capture;
    assign sample_take_c   = (state == S_CAPTURE) && sample_valid && (word_cnt < DEPTH_CNT);
    assign word_complete_c = sample_take_c && (pack_idx == 3'd7);
    assign out_accept_c    = unpack_valid && out_ready;

    // Handshake outputs are combinational on registered state only.
    assign write_req       = hold_valid && write_allowed;
    assign read_req        = (state == S_RD_ISSUE) && read_allowed && (issue_cnt < DEPTH_CNT);
    assign get_return_data = (state == S_RD_ISSUE) && has_return_data && !unpack_valid
                             && (ret_cnt < DEPTH_CNT);

    assign busy        = (state != S_IDLE);
    assign wr_adx_out  = wr_adx;
    assign wr_data_out = hold_data;
    assign rd_adx_out  = rd_adx;
    assign out_valid   = unpack_valid;
    assign out_sample  = unpack_data[{unpack_idx, 4'b0000} +: 16];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_capture)       state_nxt = S_CAPTURE;
                else if (start_readback) state_nxt = S_RD_ISSUE;
            end
            S_CAPTURE: begin
                if ((word_cnt == DEPTH_CNT) && !hold_valid) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!writes_pending) state_nxt = S_DONE;
            end
            S_RD_ISSUE: begin
                if ((ret_cnt == DEPTH_CNT) && !unpack_valid && !reads_pending)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture packing, one-entry hold register and write address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack_data    <= '0;
            pack_idx     <= '0;
            word_cnt     <= '0;
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            wr_adx       <= '0;
            overflow     <= 1'b0;
            capture_done <= 1'b0;
        end else if (start_cap_c) begin
            pack_idx     <= '0;
            word_cnt     <= '0;
            hold_valid   <= 1'b0;
            wr_adx       <= BASE_ADX;
            overflow     <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            if (sample_take_c) begin
                pack_idx <= pack_idx + 3'd1;
                for (int k = 0; k < 7; k++) begin
                    if (pack_idx == 3'(k)) pack_data[16*k +: 16] <= sample_in;
                end
            end
            if (word_complete_c) word_cnt <= word_cnt + CNT_W'(1);

            // A hold entry being written this cycle frees the slot for the new word.
            if (word_complete_c && (!hold_valid || write_req)) begin
                hold_valid <= 1'b1;
                hold_data  <= {sample_in, pack_data};
            end else if (write_req) begin
                hold_valid <= 1'b0;
            end
            if (word_complete_c && hold_valid && !write_req) overflow <= 1'b1;

            if (write_req) wr_adx <= wr_adx + STEP;

            if ((state == S_DRAIN) && !writes_pending) capture_done <= 1'b1;
        end
    end

    // Read issue and return unpacking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt    <= '0;
            rd_adx       <= '0;
            ret_cnt      <= '0;
            unpack_valid <= 1'b0;
            unpack_data  <= '0;
            unpack_idx   <= '0;
        end else if (start_rd_c) begin
            issue_cnt    <= '0;
            rd_adx       <= BASE_ADX;
            ret_cnt      <= '0;
            unpack_valid <= 1'b0;
            unpack_idx   <= '0;
        end else begin
            if (read_req) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
                rd_adx    <= rd_adx + STEP;
            end
            if (get_return_data) begin
                unpack_data  <= rd_data_return;
                unpack_valid <= 1'b1;
                unpack_idx   <= '0;
                ret_cnt      <= ret_cnt + CNT_W'(1);
            end else if (out_accept_c) begin
                unpack_idx <= unpack_idx + 3'd1;
                if (unpack_idx == 3'd7) unpack_valid <= 1'b0;
            end
        end
    end

`ifdef RD_ADX_CHECK_EN
    logic [ADX_W-1:0] exp_adx;

    // Returned addresses must follow the issue sequence; data is unpacked regardless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_adx   <= '0;
            adx_error <= 1'b0;
        end else if (start_rd_c) begin
            exp_adx   <= BASE_ADX;
            adx_error <= 1'b0;
        end else if (get_return_data) begin
            exp_adx <= exp_adx + STEP;
            if (rd_adx_return != exp_adx) adx_error <= 1'b1;
        end
    end
`else
    logic unused_rd_adx_return;
    assign unused_rd_adx_return = ^rd_adx_return;
    assign adx_error            = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_capture_client.sv
module tb_ddr_capture_client;

`ifdef RD_ADX_CHECK_EN
    localparam logic ADX_CHK = 1'b1;
`else
    localparam logic ADX_CHK = 1'b0;
`endif

    typedef struct {
        logic [26:0]  adx;
        logic [127:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: BASE 0, DEPTH 3
    logic         start_capture = 0, start_readback = 0;
    logic [15:0]  sample_in = '0;
    logic         sample_valid = 0;
    logic         busy, capture_done, overflow, adx_error;
    logic [26:0]  wr_adx_out, rd_adx_out;
    logic [127:0] wr_data_out;
    logic         write_req, read_req, get_return_data;
    logic         write_allowed = 0, writes_pending = 0;
    logic         read_allowed = 0, reads_pending = 0;
    logic [127:0] rd_data_return = '0;
    logic [26:0]  rd_adx_return = '0;
    logic         has_return_data = 0;
    logic [15:0]  out_sample;
    logic         out_valid;
    logic         out_ready = 0;

    // Instance B: wrapping base, DEPTH 2
    logic         start_capture_b = 0, write_allowed_b = 0, writes_pending_b = 0;
    logic         busy_b, capture_done_b, overflow_b, adx_error_b;
    logic [26:0]  wr_adx_b, rd_adx_b;
    logic [127:0] wr_data_b;
    logic         write_req_b, read_req_b, get_b;
    logic [15:0]  out_sample_b;
    logic         out_valid_b;

    ddr_capture_client #(.BASE_ADX(27'd0), .DEPTH_WORDS(3), .ADX_STEP(8)) u_dut (
        .clk(clk), .reset(reset),
        .start_capture(start_capture), .start_readback(start_readback),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .busy(busy), .capture_done(capture_done), .overflow(overflow), .adx_error(adx_error),
        .wr_adx_out(wr_adx_out), .wr_data_out(wr_data_out), .write_req(write_req),
        .write_allowed(write_allowed), .writes_pending(writes_pending),
        .rd_adx_out(rd_adx_out), .read_req(read_req), .read_allowed(read_allowed),
        .reads_pending(reads_pending), .rd_data_return(rd_data_return),
        .rd_adx_return(rd_adx_return), .has_return_data(has_return_data),
        .get_return_data(get_return_data), .out_sample(out_sample),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    ddr_capture_client #(.BASE_ADX(27'h7FFFFF8), .DEPTH_WORDS(2), .ADX_STEP(8)) u_wrap (
        .clk(clk), .reset(reset),
        .start_capture(start_capture_b), .start_readback(1'b0),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .busy(busy_b), .capture_done(capture_done_b), .overflow(overflow_b),
        .adx_error(adx_error_b),
        .wr_adx_out(wr_adx_b), .wr_data_out(wr_data_b), .write_req(write_req_b),
        .write_allowed(write_allowed_b), .writes_pending(writes_pending_b),
        .rd_adx_out(rd_adx_b), .read_req(read_req_b), .read_allowed(1'b0),
        .reads_pending(1'b0), .rd_data_return(128'd0),
        .rd_adx_return(27'd0), .has_return_data(1'b0),
        .get_return_data(get_b), .out_sample(out_sample_b),
        .out_valid(out_valid_b), .out_ready(1'b0)
    );

    int errors = 0;
    int checks = 0;

    ent_t        exp_wr[$];
    ent_t        exp_wr_b[$];
    logic [26:0] exp_rd[$];
    logic [15:0] exp_smp[$];
    ent_t        mem_q[$];
    int          get_cnt = 0;
    bit          corrupt_8 = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word k holds samples 8k..8k+7, sample j at bits [16j+15:16j].
    function automatic logic [127:0] word_data(input int k);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(8*k + j);
        return w;
    endfunction

    // Memory model: returns each read the cycle after issue, in order.
    always @(posedge clk) begin
        ent_t e;
        if (read_req) begin
            e.adx  = (corrupt_8 && rd_adx_out == 27'd8) ? 27'd16 : rd_adx_out;
            e.data = word_data(int'(rd_adx_out) / 8);
            mem_q.push_back(e);
        end
        if (get_return_data && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            get_cnt++;
        end
        has_return_data <= (mem_q.size() > 0);
        reads_pending   <= (mem_q.size() > 0);
        if (mem_q.size() > 0) begin
            rd_data_return <= mem_q[0].data;
            rd_adx_return  <= mem_q[0].adx;
        end
    end

    // Background handshake pacing for readback.
    initial begin
        int tick = 0;
        forever begin
            @(posedge clk); #1;
            tick++;
            out_ready    = (tick % 4) != 1;
            read_allowed = tick[0];
        end
    end

    // Monitors: pop the scoreboard whenever the DUT presents a transaction.
    logic        stall_prev = 0;
    logic [15:0] held_sample = '0;
    always @(negedge clk) begin
        ent_t e;
        logic [26:0] a;
        logic [15:0] s;
        if (!reset) begin
            if (write_req) begin
                if (exp_wr.size() == 0) check("unexpected_write", {wr_adx_out}, 128'hDEAD);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_adx", {101'd0, wr_adx_out}, {101'd0, e.adx});
                    check("wr_data", wr_data_out, e.data);
                end
            end
            if (write_req_b) begin
                if (exp_wr_b.size() == 0) check("unexpected_write_b", {wr_adx_b}, 128'hDEAD);
                else begin
                    e = exp_wr_b.pop_front();
                    check("wr_adx_b", {101'd0, wr_adx_b}, {101'd0, e.adx});
                    check("wr_data_b", wr_data_b, e.data);
                end
            end
            if (read_req) begin
                if (exp_rd.size() == 0) check("unexpected_read", {rd_adx_out}, 128'hDEAD);
                else begin
                    a = exp_rd.pop_front();
                    check("rd_adx", {101'd0, rd_adx_out}, {101'd0, a});
                end
            end
            if (stall_prev) check("out_sample_hold", {out_valid, out_sample}, {1'b1, held_sample});
            if (out_valid && out_ready) begin
                if (exp_smp.size() == 0) check("unexpected_sample", {out_sample}, 128'hDEAD);
                else begin
                    s = exp_smp.pop_front();
                    check("out_sample", {112'd0, out_sample}, {112'd0, s});
                end
            end
            stall_prev  = out_valid && !out_ready;
            held_sample = out_sample;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic run_capture(input int n, input logic [15:0] base, input bit use_b);
        @(posedge clk); #1;
        if (use_b) start_capture_b = 1; else start_capture = 1;
        @(posedge clk); #1;
        start_capture = 0; start_capture_b = 0;
        for (int i = 0; i < n; i++) begin
            sample_in = base + 16'(i); sample_valid = 1;
            @(posedge clk); #1;
        end
        sample_valid = 0;
    endtask

    task automatic wait_flag(input string name, input bit which_b);
        int n = 0;
        while (n < 200 && !(which_b ? capture_done_b : capture_done)) begin
            @(negedge clk); n++;
        end
        check(name, {127'd0, which_b ? capture_done_b : capture_done}, 128'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (n < 400 && busy) begin
            @(negedge clk); n++;
        end
        check(name, {127'd0, busy}, 128'd0);
    endtask

    task automatic run_readback;
        for (int k = 0; k < 3; k++) exp_rd.push_back(27'(8*k));
        for (int i = 0; i < 24; i++) exp_smp.push_back(16'(i));
        @(posedge clk); #1; start_readback = 1;
        @(posedge clk); #1; start_readback = 0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, capture_done, overflow, adx_error, write_req, read_req,
                     get_return_data, out_valid, out_sample, wr_adx_out, rd_adx_out},
              128'd0);
        check({name, "_wr_data"}, wr_data_out, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        int   n;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        reset = 0;

        // 1: continuous capture with writes accepted
        for (int k = 0; k < 3; k++) begin
            e.adx = 27'(8*k); e.data = word_data(k); exp_wr.push_back(e);
        end
        check("word0_literal", word_data(0), 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        write_allowed = 1; writes_pending = 1;
        run_capture(24, 16'h0000, 0);
        repeat (5) @(negedge clk);
        check("t1_done_held_by_pending", {126'd0, busy, capture_done}, {126'd0, 2'b10});
        check("t1_writes_seen", exp_wr.size(), 0);
        @(posedge clk); #1; writes_pending = 0;
        wait_flag("t1_capture_done", 0);
        check("t1_overflow", {127'd0, overflow}, 128'd0);

        // 2: writes blocked -> first word held, later words dropped
        write_allowed = 0; writes_pending = 1;
        e.adx = 27'd0; e.data = word_data(0); exp_wr.push_back(e);
        run_capture(24, 16'h0000, 0);
        repeat (3) @(negedge clk);
        check("t2_overflow", {126'd0, overflow, capture_done}, {126'd0, 2'b10});
        check("t2_no_write_yet", exp_wr.size(), 1);
        @(posedge clk); #1; write_allowed = 1;
        repeat (4) @(posedge clk);
        #1; writes_pending = 0;
        wait_flag("t2_capture_done", 0);
        check("t2_one_write", exp_wr.size(), 0);
        check("t2_overflow_sticky", {127'd0, overflow}, 128'd1);

        // 3: readback with paced read_allowed / out_ready
        run_readback();
        wait_idle("t3_idle");
        check("t3_reads_left", exp_rd.size(), 0);
        check("t3_samples_left", exp_smp.size(), 0);
        check("t3_adx_error", {127'd0, adx_error}, 128'd0);

        // 4: return address 16 where 8 expected
        corrupt_8 = 1;
        run_readback();
        wait_idle("t4_idle");
        corrupt_8 = 0;
        check("t4_samples_left", exp_smp.size(), 0);
        check("t4_adx_error", {127'd0, adx_error}, {127'd0, ADX_CHK});

        // 5: reset mid-readback after the first return
        n = get_cnt;
        run_readback();
        begin
            int w = 0;
            while (w < 200 && get_cnt < n + 1) begin
                @(negedge clk); w++;
            end
            check("t5_first_return", get_cnt - n, 1);
        end
        @(posedge clk); #2;
        reset = 1;
        #1;
        check_all_zero("t5_reset_outputs");
        exp_rd.delete(); exp_smp.delete(); mem_q.delete();
        repeat (2) @(posedge clk);
        #1; reset = 0;
        check("t5_idle", {127'd0, busy}, 128'd0);
        for (int k = 0; k < 3; k++) begin
            e.adx = 27'(8*k); e.data = word_data(32 + k); exp_wr.push_back(e);
        end
        write_allowed = 1; writes_pending = 0;
        run_capture(24, 16'h0100, 0);
        wait_flag("t5_capture_done", 0);
        check("t5_writes_left", exp_wr.size(), 0);

        // 6: address wrap at the top of the 27-bit space
        e.adx = 27'h7FFFFF8; e.data = word_data(0); exp_wr_b.push_back(e);
        e.adx = 27'h0000000; e.data = word_data(1); exp_wr_b.push_back(e);
        write_allowed_b = 1; writes_pending_b = 0;
        run_capture(16, 16'h0000, 1);
        wait_flag("t6_capture_done", 1);
        check("t6_writes_left", exp_wr_b.size(), 0);
        check("t6_overflow", {127'd0, overflow_b}, 128'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
